// File: rtl/v0_display_scanner.sv
// Multiplexed 4-digit hex display of the CPU $v0 register, paging between halfwords.
// Optional leading-zero blanking: define V0_DISP_BLANK_LEADING_ZERO_EN.
module v0_display_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int PAGE_DIV    = 1000
) (
  input  logic        CLK_IN,
  input  logic        GLOBALRESET,
  input  logic [31:0] value_in,
  input  logic        load_in,
  input  logic        hold_in,
  output logic [6:0]  seg_out,
  output logic [3:0]  digit_out,
  output logic        page_out
);

  localparam logic [19:0] REFRESH_MAX = 20'(REFRESH_DIV - 1);
  localparam logic [15:0] PAGE_MAX    = 16'(PAGE_DIV - 1);

  logic [31:0] shadow;
  logic [19:0] refresh_cnt;
  logic [1:0]  index;
  logic [15:0] scan_cnt;

  logic        refresh_wrap;
  logic        scan_done;
  logic [15:0] half;
  logic [3:0]  nibble;
  logic        blank;
  logic [6:0]  seg_next;
  logic [3:0]  digit_next;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0:    hex_glyph = 7'b1000000;
      4'h1:    hex_glyph = 7'b1111001;
      4'h2:    hex_glyph = 7'b0100100;
      4'h3:    hex_glyph = 7'b0110000;
      4'h4:    hex_glyph = 7'b0011001;
      4'h5:    hex_glyph = 7'b0010010;
      4'h6:    hex_glyph = 7'b0000010;
      4'h7:    hex_glyph = 7'b1111000;
      4'h8:    hex_glyph = 7'b0000000;
      4'h9:    hex_glyph = 7'b0010000;
      4'hA:    hex_glyph = 7'b0001000;
      4'hB:    hex_glyph = 7'b0000011;
      4'hC:    hex_glyph = 7'b1000110;
      4'hD:    hex_glyph = 7'b0100001;
      4'hE:    hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    refresh_wrap = (refresh_cnt == REFRESH_MAX);
    scan_done    = refresh_wrap && (index == 2'd3);
    half         = page_out ? shadow[31:16] : shadow[15:0];
    nibble       = half[{index, 2'b00} +: 4];
`ifdef V0_DISP_BLANK_LEADING_ZERO_EN
    // A digit is a leading zero when it and everything above it in the halfword is zero.
    blank        = (index != 2'd0) && ((half >> {index, 2'b00}) == 16'd0);
`else
    blank        = 1'b0;
`endif
    seg_next     = blank ? 7'b1111111 : hex_glyph(nibble);
    digit_next   = ~(4'b0001 << index);
  end

  // Outputs are registered from the current state, so they trail index/page/shadow by one edge.
  always_ff @(posedge CLK_IN) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values, so a load
    // coinciding with an index wrap reaches the outputs together on the following edge.
    if (GLOBALRESET) begin
      shadow      <= '0;
      refresh_cnt <= '0;
      index       <= '0;
      scan_cnt    <= '0;
      page_out    <= 1'b0;
      seg_out     <= 7'b1111111;
      digit_out   <= 4'b1111;
    end else begin
      if (load_in) shadow <= value_in;

      refresh_cnt <= refresh_wrap ? 20'd0 : refresh_cnt + 20'd1;
      if (refresh_wrap) index <= index + 2'd1;

      if (hold_in) begin
        scan_cnt <= '0;
      end else if (scan_done) begin
        if (scan_cnt >= PAGE_MAX) begin
          scan_cnt <= '0;
          page_out <= ~page_out;
        end else begin
          scan_cnt <= scan_cnt + 16'd1;
        end
      end

      seg_out   <= seg_next;
      digit_out <= digit_next;
    end
  end

endmodule

// File: tb/tb_v0_display_scanner.sv
// Self-checking bench: timing model keyed on cycles since reset release, hex table, corner sequences.
module tb_v0_display_scanner;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic [31:0] value0 = '0, value1 = '0;
  logic        load0 = 1'b0, load1 = 1'b0;
  logic        hold0 = 1'b0, hold1 = 1'b0;
  logic [6:0]  seg0, seg1;
  logic [3:0]  digit0, digit1;
  logic        page0, page1;

  always #5 clk = ~clk;

  v0_display_scanner #(.REFRESH_DIV(4), .PAGE_DIV(2)) dut0 (
    .CLK_IN(clk), .GLOBALRESET(rst0), .value_in(value0), .load_in(load0),
    .hold_in(hold0), .seg_out(seg0), .digit_out(digit0), .page_out(page0)
  );

  v0_display_scanner #(.REFRESH_DIV(1), .PAGE_DIV(1)) dut1 (
    .CLK_IN(clk), .GLOBALRESET(rst1), .value_in(value1), .load_in(load1),
    .hold_in(hold1), .seg_out(seg1), .digit_out(digit1), .page_out(page1)
  );

  typedef struct {
    logic [6:0] seg;
    logic [3:0] digit;
    logic       page;
  } exp_t;

  typedef struct {
    logic [31:0] value;
    logic [6:0]  seg;
  } vec_t;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [31:0] sh0 = '0, sh1 = '0;
  vec_t        vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected outputs after edge k (k=1 is the first edge after reset release), given the
  // shadow value the DUT held just before that edge.
  function automatic exp_t model(input int k, input int r, input int p, input logic [31:0] sh);
    exp_t        e;
    int          el, idx, pg_pre;
    logic [15:0] half;
    logic [3:0]  nib;
    el     = k - 1;
    idx    = (el / r) % 4;
    pg_pre = (el / (r * 4 * p)) % 2;
    half   = (pg_pre == 1) ? sh[31:16] : sh[15:0];
    nib    = half[idx*4 +: 4];
    e.seg  = glyph_tab[nib];
`ifdef V0_DISP_BLANK_LEADING_ZERO_EN
    if (idx != 0 && (half >> (idx * 4)) == 16'd0) e.seg = 7'b1111111;
`endif
    e.digit = ~(4'b0001 << idx);
    e.page  = ((k / (r * 4 * p)) % 2) == 1;
    return e;
  endfunction

  task automatic step(input int k, input bit sel);
    exp_t e;
    exp_t g;
    e = sel ? model(k, 1, 1, sh1) : model(k, 4, 2, sh0);
    sb.push_back(e);
    tick();
    if (!sel && load0) sh0 = value0;
    if (sel && load1)  sh1 = value1;
    g = sb.pop_front();
    check($sformatf("seg%0d k=%0d", sel, k),   sel ? 32'(seg1)   : 32'(seg0),   32'(g.seg));
    check($sformatf("digit%0d k=%0d", sel, k), sel ? 32'(digit1) : 32'(digit0), 32'(g.digit));
    check($sformatf("page%0d k=%0d", sel, k),  sel ? 32'(page1)  : 32'(page0),  32'(g.page));
  endtask

  task automatic reset0();
    rst0  = 1'b1;
    load0 = 1'b0;
    hold0 = 1'b0;
    tick();
    sh0  = '0;
    rst0 = 1'b0;
  endtask

  initial begin
    vecs = '{
      '{32'hFFFF_FFF0, 7'b1000000}, '{32'h0000_0001, 7'b1111001},
      '{32'h1234_5672, 7'b0100100}, '{32'hDEAD_BEE3, 7'b0110000},
      '{32'h0000_0014, 7'b0011001}, '{32'h8000_0005, 7'b0010010},
      '{32'h0F0F_0F06, 7'b0000010}, '{32'h0000_0007, 7'b1111000},
      '{32'hCAFE_F008, 7'b0000000}, '{32'h0000_0009, 7'b0010000},
      '{32'hABCD_EF0A, 7'b0001000}, '{32'h0000_000B, 7'b0000011},
      '{32'h7777_777C, 7'b1000110}, '{32'h0000_000D, 7'b0100001},
      '{32'h1111_111E, 7'b0000110}, '{32'hFFFF_FFFF, 7'b0001110}
    };

    // Reset state
    tick();
    check("reset seg", 32'(seg0), 32'h7F);
    check("reset digit", 32'(digit0), 32'hF);
    check("reset page", 32'(page0), 32'h0);

    // Hex encoding table: load is visible two edges after capture on digit 0
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      exp_t g;
      reset0();
      load0  = 1'b1;
      value0 = vecs[i].value;
      tick();
      load0 = 1'b0;
      e.seg = vecs[i].seg; e.digit = 4'b1110; e.page = 1'b0;
      sb.push_back(e);
      tick();
      g = sb.pop_front();
      check($sformatf("hex seg %0d", i), 32'(seg0), 32'(g.seg));
      check($sformatf("hex digit %0d", i), 32'(digit0), 32'(g.digit));
    end

    // Scan and paging, with a reload that coincides with an index advance at edge 8
    reset0();
    for (int k = 1; k <= 70; k++) begin
      load0 = (k == 1) || (k == 8);
      if (k == 1) value0 = 32'h1234_ABCD;
      if (k == 8) value0 = 32'h8765_4321;
      step(k, 1'b0);
    end
    load0 = 1'b0;

    // Reset in the middle of digit 2 on page 1
    reset0();
    for (int k = 1; k <= 42; k++) begin
      load0  = (k == 1);
      value0 = 32'h1234_ABCD;
      step(k, 1'b0);
    end
    load0 = 1'b0;
    check("pre-reset page", 32'(page0), 32'h1);
    rst0 = 1'b1;
    tick();
    check("midreset seg", 32'(seg0), 32'h7F);
    check("midreset digit", 32'(digit0), 32'hF);
    check("midreset page", 32'(page0), 32'h0);
    sh0  = '0;
    rst0 = 1'b0;
    tick();
    check("release seg", 32'(seg0), 32'(7'b1000000));
    check("release digit", 32'(digit0), 32'(4'b1110));
    for (int k = 2; k <= 8; k++) step(k, 1'b0);

    // Hold across two scan boundaries, then exactly two scans to the toggle
    reset0();
    for (int k = 1; k <= 64; k++) begin
      load0  = (k == 1);
      value0 = 32'h1234_ABCD;
      hold0  = (k <= 40);
      tick();
      check($sformatf("hold page k=%0d", k), 32'(page0), (k >= 64) ? 32'h1 : 32'h0);
    end
    load0 = 1'b0;
    hold0 = 1'b0;

    // Leading-zero behaviour on a small value
    reset0();
    for (int k = 1; k <= 17; k++) begin
      load0  = (k == 1);
      value0 = 32'h0000_0007;
      step(k, 1'b0);
      if (k == 6) begin
`ifdef V0_DISP_BLANK_LEADING_ZERO_EN
        check("lz digit1", 32'(seg0), 32'h7F);
`else
        check("lz digit1", 32'(seg0), 32'(7'b1000000));
`endif
      end
    end
    load0 = 1'b0;

    // Minimum dividers: index every cycle, page every scan
    rst1 = 1'b1;
    tick();
    check("dut1 reset digit", 32'(digit1), 32'hF);
    sh1  = '0;
    rst1 = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      load1  = (k == 1);
      value1 = 32'h1234_ABCD;
      step(k, 1'b1);
    end
    load1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/v0_display_scanner.md
V0_DISPLAY_SCANNER -- requirements
Module: v0_display_scanner

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles each digit stays lit (legal range 1..2^20).
REQ-002 The block SHALL have parameter PAGE_DIV, default 1000, giving the full 4-digit scans per halfword page (legal range 1..2^16).
REQ-003 The block SHALL have port CLK_IN, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port GLOBALRESET, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port value_in, input, 32 bits, the CPU $v0 register value.
REQ-006 The block SHALL have port load_in, input, 1 bit, a capture strobe for value_in.
REQ-007 The block SHALL have port hold_in, input, 1 bit, which freezes the current page.
REQ-008 The block SHALL have port seg_out, output, 7 bits, active-low segments, with bit0=a through bit6=g.
REQ-009 The block SHALL have port digit_out, output, 4 bits, active-low digit enables, with bit0 as the rightmost digit.
REQ-010 The block SHALL have port page_out, output, 1 bit, where 0 means bits [15:0] are shown and 1 means bits [31:16] are shown.

Function
REQ-011 The block SHALL hold a 32-bit shadow register that loads value_in on every edge where load_in=1 and otherwise keeps its value.
REQ-012 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; the digit index (0..3) SHALL advance only on the cycle the refresh counter wraps.
REQ-013 The digit index SHALL wrap from 3 to 0; each such wrap SHALL complete one scan.
REQ-014 On a scan completion with hold_in=0, the scan counter SHALL increment, and at PAGE_DIV-1 it SHALL clear and toggle page_out instead.
REQ-015 While hold_in=1, the scan counter SHALL be held at 0 and page_out SHALL not change; after release, a full PAGE_DIV scans SHALL elapse before the next toggle.
REQ-016 With REFRESH_DIV=1, the digit index SHALL advance every cycle; with PAGE_DIV=1, the page SHALL toggle on every scan completion.
REQ-017 The displayed nibble SHALL be shadow[page*16 + index*4 +: 4].
REQ-018 digit_out SHALL drive only bit[index] low.
REQ-019 seg_out and digit_out SHALL be registered, reflecting the index, page and shadow values one cycle after they change, so a load_in strobe is visible on the outputs two edges after capture.
REQ-020 The hex encoding on seg_out[6:0] SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 When load_in coincides with an index or page change, the new shadow value and the new index/page SHALL take effect together on the next output update.

Reset
REQ-022 While GLOBALRESET=1 at an edge, the block SHALL clear the shadow, refresh counter, index, scan counter and page_out to 0.
REQ-023 While GLOBALRESET=1 at an edge, the block SHALL set seg_out to 1111111 and digit_out to 1111 (all blank).
REQ-024 Reset asserted mid-scan SHALL abandon the current digit immediately, with no partial-cycle output.
REQ-025 On the first edge after reset deasserts, the outputs SHALL show index 0, page 0 (digit_out=1110, seg_out=1000000).

Configuration
REQ-026 When macro V0_DISP_BLANK_LEADING_ZERO_EN is defined, digits 3..1 of the current page SHALL be blanked (seg_out=1111111, digit enable still driven) while their nibble and every higher nibble of that halfword are 0; digit 0 SHALL never be blanked.
REQ-027 When V0_DISP_BLANK_LEADING_ZERO_EN is undefined, every digit SHALL always show its hex glyph.

Verification (REFRESH_DIV=4, PAGE_DIV=2 unless stated)
REQ-028 Reset then load value_in=0x1234ABCD -> page 0 cycles through D,C,B,A with digit_out 1110,1101,1011,0111, each lasting 4 cycles; seg_out for D is 0100001.
REQ-029 Run 2 full scans (32 cycles) -> page_out becomes 1 and the digits show 4,3,2,1; after 32 more cycles page_out returns to 0.
REQ-030 Assert hold_in across a scan boundary -> page_out stays constant; after release, the toggle occurs exactly 2 scans later.
REQ-031 Assert GLOBALRESET mid-digit-2 on page 1 -> next edge gives seg_out=1111111, digit_out=1111, page_out=0 and shadow 0; after release, digit_out=1110 with seg 1000000.
REQ-032 With the macro defined, load 0x00000007 -> digit0 shows 1111000 and digits 1-3 show 1111111; without the macro, digits 1-3 show 1000000.
REQ-033 With REFRESH_DIV=1 and PAGE_DIV=1 -> the index advances every cycle and page_out toggles every 4 cycles.
